// File: rtl/rx_frame_checker.sv
// Buffers one rx frame, checks CRC_A over full bytes; status valid one cycle after eoc, held until frame_ack.
// No backpressure on rx: frames arriving while one is held are discarded and reported via frame_dropped.
module rx_frame_checker #(
    parameter int MAX_BYTES = 64,
    localparam int CW = $clog2(MAX_BYTES + 1),
    localparam int AW = $clog2(MAX_BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          soc,
    input  logic          eoc,
    input  logic [7:0]    data,
    input  logic [2:0]    data_bits,
    input  logic          data_valid,
    input  logic          sequence_error,
    input  logic          parity_error,
    input  logic          last_bit,
    output logic          frame_valid,
    input  logic          frame_ack,
    output logic [CW-1:0] frame_bytes,
    output logic [2:0]    frame_bits,
    output logic          crc_ok,
    output logic          parity_err,
    output logic          seq_err,
    output logic          overflow,
    output logic          frame_dropped,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_HELD} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [2:0]    r_bits;
    logic [15:0]   r_crc;
    logic          r_par;
    logic          r_seq;
    logic          r_ovf;
    logic          r_dropped;
    logic [7:0]    r_mem [MAX_BYTES];

    logic w_start;
    logic w_release;
    logic w_accept;
    logic w_room;
    logic w_full_byte;
    logic w_unused;

    assign w_unused    = last_bit;
    assign w_release   = (r_state == S_HELD) && frame_ack;
    // soc while held only counts when the same cycle releases the buffer
    assign w_start     = soc && ((r_state != S_HELD) || frame_ack);
    assign w_accept    = (r_state == S_RECV) && !soc;
    assign w_room      = r_count < CW'(MAX_BYTES);
    assign w_full_byte = w_accept && data_valid && (r_bits == 3'd0) && (data_bits == 3'd0);

    function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (soc) w_state_nxt = S_RECV;
            S_RECV:  if (!soc && eoc) w_state_nxt = S_HELD;
            S_HELD:  if (frame_ack) w_state_nxt = soc ? S_RECV : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        frame_valid = 1'b0;
        frame_bytes = '0;
        frame_bits  = 3'd0;
        crc_ok      = 1'b0;
        parity_err  = 1'b0;
        seq_err     = 1'b0;
        overflow    = 1'b0;
        if (r_state == S_HELD) begin
            frame_valid = 1'b1;
            frame_bytes = r_count;
            frame_bits  = r_bits;
            crc_ok      = (r_crc == 16'h0000) && (r_bits == 3'd0) && (r_count >= CW'(3)) && !r_ovf;
            parity_err  = r_par;
            seq_err     = r_seq;
            overflow    = r_ovf;
        end
    end

    assign frame_dropped = r_dropped;
    assign rd_data       = r_mem[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_bits    <= 3'd0;
            r_crc     <= 16'h6363;
            r_par     <= 1'b0;
            r_seq     <= 1'b0;
            r_ovf     <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= (r_state == S_HELD) && eoc;
            if (w_start || w_release) begin
                r_count <= '0;
                r_bits  <= 3'd0;
                r_crc   <= 16'h6363;
                r_par   <= 1'b0;
                r_seq   <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_accept) begin
                if (parity_error)   r_par <= 1'b1;
                if (sequence_error) r_seq <= 1'b1;
                if (data_valid) begin
                    // nothing may follow a partial final byte
                    if (r_bits != 3'd0) begin
                        r_seq <= 1'b1;
                    end else if (data_bits == 3'd0) begin
                        r_crc <= f_crc_byte(r_crc, data);
                        if (w_room) r_count <= r_count + CW'(1);
                        else        r_ovf   <= 1'b1;
                    end else begin
                        r_bits <= data_bits;
                        if (!w_room) r_ovf <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && data_valid && (r_bits == 3'd0) && w_room) begin
            r_mem[r_count[AW-1:0]] <= data;
        end
    end

    // keep lint quiet about the otherwise write-only full-byte strobe
    logic w_unused_fb;
    assign w_unused_fb = w_full_byte;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed frames against rx_frame_checker; expected frame records queued by the stimulus, checked by a monitor.
module tb_rx_frame_checker;

    typedef struct {
        int         rise;
        int         nbytes;
        int         nbits;
        bit         ok;
        bit         par;
        bit         seq;
        bit         ovf;
        int         nchk;
        logic [5:0] a0;
        logic [7:0] d0;
        logic [5:0] a1;
        logic [7:0] d1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, soc, eoc, data_valid, sequence_error, parity_error, last_bit, frame_ack;
    logic [7:0] data;
    logic [2:0] data_bits;
    logic [5:0] rd_addr;
    logic       frame_valid, crc_ok, parity_err, seq_err, overflow, frame_dropped;
    logic [6:0] frame_bytes;
    logic [2:0] frame_bits;
    logic [7:0] rd_data;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   drops_seen = 0;
    int   drops_exp = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rx_frame_checker #(.MAX_BYTES(64)) dut (
        .clk(clk), .rst_n(rst_n), .soc(soc), .eoc(eoc), .data(data), .data_bits(data_bits),
        .data_valid(data_valid), .sequence_error(sequence_error), .parity_error(parity_error),
        .last_bit(last_bit), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .frame_bytes(frame_bytes), .frame_bits(frame_bits), .crc_ok(crc_ok),
        .parity_err(parity_err), .seq_err(seq_err), .overflow(overflow),
        .frame_dropped(frame_dropped), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(int nb, int nbits, bit ok, bit par, bit seq, bit ovf, int nchk,
                                logic [5:0] a0, logic [7:0] d0, logic [5:0] a1, logic [7:0] d1);
        exp_t e;
        e.rise = 0; e.nbytes = nb; e.nbits = nbits; e.ok = ok; e.par = par; e.seq = seq;
        e.ovf = ovf; e.nchk = nchk; e.a0 = a0; e.d0 = d0; e.a1 = a1; e.d1 = d1;
        return e;
    endfunction

    // Monitor: latency check on frame_valid rise, full compare at the consumer handshake.
    initial begin
        bit   prev;
        exp_t e;
        prev    = 1'b0;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (frame_dropped) drops_seen++;
                if (frame_valid && !prev) begin
                    if (sb.size() == 0) chk("sb_nonempty_at_rise", 32'(sb.size()), 1);
                    else                chk("valid_latency", 32'(cyc), 32'(sb[0].rise));
                end
                if (frame_valid && frame_ack) begin
                    if (sb.size() == 0) begin
                        chk("sb_nonempty_at_ack", 32'(sb.size()), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("frame_bytes", 32'(frame_bytes), 32'(e.nbytes));
                        chk("frame_bits",  32'(frame_bits),  32'(e.nbits));
                        chk("crc_ok",      32'(crc_ok),      32'(e.ok));
                        chk("parity_err",  32'(parity_err),  32'(e.par));
                        chk("seq_err",     32'(seq_err),     32'(e.seq));
                        chk("overflow",    32'(overflow),    32'(e.ovf));
                        if (e.nchk > 0) begin
                            rd_addr = e.a0; #1;
                            chk("rd_data_a", 32'(rd_data), 32'(e.d0));
                        end
                        if (e.nchk > 1) begin
                            rd_addr = e.a1; #1;
                            chk("rd_data_b", 32'(rd_data), 32'(e.d1));
                        end
                    end
                end
                prev = frame_valid;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_soc();
        soc = 1'b1; step(); soc = 1'b0;
    endtask

    task automatic do_byte(input logic [7:0] b, input logic [2:0] nb);
        data = b; data_bits = nb; data_valid = 1'b1;
        step();
        data_valid = 1'b0; data_bits = 3'd0;
    endtask

    task automatic do_bytes4(input logic [7:0] b0, b1, b2, b3);
        do_byte(b0, 3'd0); do_byte(b1, 3'd0); do_byte(b2, 3'd0); do_byte(b3, 3'd0);
    endtask

    task automatic do_eoc(input exp_t e, input bit with_byte, input logic [7:0] b);
        e.rise = cyc + 1;
        sb.push_back(e);
        eoc = 1'b1;
        if (with_byte) begin
            data = b; data_bits = 3'd0; data_valid = 1'b1;
        end
        step();
        eoc = 1'b0; data_valid = 1'b0;
    endtask

    task automatic eoc_plain();
        eoc = 1'b1; step(); eoc = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!frame_valid && n < 10) begin
            step(); n++;
        end
        if (!frame_valid) chk("wait_valid", 32'(frame_valid), 1);
    endtask

    task automatic ack_frame();
        wait_valid();
        frame_ack = 1'b1; step(); frame_ack = 1'b0;
        chk("released", 32'({frame_valid, frame_bytes, crc_ok}), 0);
    endtask

    initial begin
        rst_n = 1'b0; soc = 1'b0; eoc = 1'b0; data_valid = 1'b0; data = 8'h00; data_bits = 3'd0;
        sequence_error = 1'b0; parity_error = 1'b0; last_bit = 1'b0; frame_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({frame_valid, frame_bytes, frame_bits, crc_ok, parity_err,
                                  seq_err, overflow, frame_dropped}), 0);
        rst_n = 1'b1;
        step();

        // data and eoc in IDLE without soc must be ignored
        do_byte(8'h99, 3'd0); eoc_plain(); step();
        chk("idle_ignore", 32'(frame_valid), 0);

        do_soc(); do_bytes4(8'h00, 8'h00, 8'hA0, 8'h1E);
        do_eoc(mk(4, 0, 1, 0, 0, 0, 2, 6'd3, 8'h1E, 6'd2, 8'hA0), 1'b0, 8'h00);
        ack_frame();

        // last byte arrives with eoc
        do_soc(); do_byte(8'h12, 3'd0); do_byte(8'h34, 3'd0); do_byte(8'h26, 3'd0);
        do_eoc(mk(4, 0, 1, 0, 0, 0, 2, 6'd3, 8'hCF, 6'd0, 8'h12), 1'b1, 8'hCF);
        ack_frame();

        do_soc(); do_bytes4(8'h12, 8'h34, 8'h26, 8'hCE);
        do_eoc(mk(4, 0, 0, 0, 0, 0, 2, 6'd3, 8'hCE, 6'd2, 8'h26), 1'b0, 8'h00);
        ack_frame();

        do_soc(); do_byte(8'h26, 3'd7);
        do_eoc(mk(0, 7, 0, 0, 0, 0, 1, 6'd0, 8'h26, 6'd0, 8'h26), 1'b0, 8'h00);
        ack_frame();

        do_soc();
        for (int i = 0; i < 66; i++) do_byte(8'(i), 3'd0);
        do_eoc(mk(64, 0, 0, 0, 0, 1, 2, 6'd63, 8'h3F, 6'd0, 8'h00), 1'b0, 8'h00);
        ack_frame();

        // second frame while the first is held is dropped
        do_soc(); do_bytes4(8'h00, 8'h00, 8'hA0, 8'h1E);
        do_eoc(mk(4, 0, 1, 0, 0, 0, 2, 6'd3, 8'h1E, 6'd1, 8'h00), 1'b0, 8'h00);
        wait_valid();
        do_soc(); do_byte(8'h55, 3'd0); do_byte(8'h66, 3'd0); do_byte(8'h77, 3'd0);
        drops_exp++;
        eoc_plain(); step(); step();
        ack_frame();

        do_soc(); do_byte(8'h12, 3'd0);
        parity_error = 1'b1; step(); parity_error = 1'b0;
        do_byte(8'h34, 3'd0); do_byte(8'h26, 3'd0); do_byte(8'hCF, 3'd0);
        do_eoc(mk(4, 0, 1, 1, 0, 0, 1, 6'd0, 8'h12, 6'd0, 8'h12), 1'b0, 8'h00);
        ack_frame();

        do_soc(); do_byte(8'h26, 3'd7); do_byte(8'h55, 3'd0);
        do_eoc(mk(0, 7, 0, 0, 1, 0, 0, 6'd0, 8'h00, 6'd0, 8'h00), 1'b0, 8'h00);
        ack_frame();

        do_soc();
        sequence_error = 1'b1; step(); sequence_error = 1'b0;
        do_bytes4(8'h00, 8'h00, 8'hA0, 8'h1E);
        do_eoc(mk(4, 0, 1, 0, 1, 0, 1, 6'd3, 8'h1E, 6'd3, 8'h1E), 1'b0, 8'h00);
        ack_frame();

        // soc mid-frame restarts; soc with ack releases and starts the next frame
        do_soc(); do_byte(8'hFF, 3'd0); do_byte(8'hFF, 3'd0);
        do_soc(); do_bytes4(8'h00, 8'h00, 8'hA0, 8'h1E);
        do_eoc(mk(4, 0, 1, 0, 0, 0, 2, 6'd0, 8'h00, 6'd3, 8'h1E), 1'b0, 8'h00);
        wait_valid();
        soc = 1'b1; frame_ack = 1'b1; step(); soc = 1'b0; frame_ack = 1'b0;
        chk("soc_ack_release", 32'(frame_valid), 0);
        do_bytes4(8'h12, 8'h34, 8'h26, 8'hCF);
        do_eoc(mk(4, 0, 1, 0, 0, 0, 1, 6'd3, 8'hCF, 6'd3, 8'hCF), 1'b0, 8'h00);
        ack_frame();

        do_soc(); do_byte(8'h11, 3'd0); do_byte(8'h22, 3'd0);
        rst_n = 1'b0; #1;
        chk("reset_mid_recv", 32'({frame_valid, frame_bytes, frame_bits, crc_ok, parity_err,
                                   seq_err, overflow, frame_dropped}), 0);
        step(); rst_n = 1'b1; step();
        eoc_plain(); step();
        chk("idle_after_reset", 32'(frame_valid), 0);
        do_soc(); do_bytes4(8'h00, 8'h00, 8'hA0, 8'h1E);
        do_eoc(mk(4, 0, 1, 0, 0, 0, 2, 6'd0, 8'h00, 6'd3, 8'h1E), 1'b0, 8'h00);
        ack_frame();

        repeat (3) step();
        chk("sb_empty", 32'(sb.size()), 0);
        chk("drop_pulses", 32'(drops_seen), 32'(drops_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
